mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 The block SHALL have parameter LEN_W, default 3: width of the per-request pair count field.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req  in  2  per-requester request, bit i = requester i.
REQ-005 len  in  2*LEN_W  pair count minus 1 for each requester, requester i in slice i; sampled at grant.
REQ-006 op_valid  in  2  per-requester operand valid.
REQ-007 op_a, op_b  in  4 each  2-bit operands for each requester, requester i in bits [2i+1:2i].
REQ-008 op_ready  out  2  operand accept, asserted only toward the granted requester.
REQ-009 grant  out  2  one-hot grant; 00 when idle.
REQ-010 mac_a, mac_b  out  2 each  MAC multiplier operands, registered.
REQ-011 mac_en  out  1  MAC accumulate strobe, registered; one cycle per accepted pair.
REQ-012 mac_clr  out  1  one-cycle accumulator clear pulse to the MAC.
REQ-013 mac_out  in  8  MAC accumulator value.
REQ-014 rsp_valid/rsp_ready  out/in  1 each  result handshake.
REQ-015 rsp_id  out  1  requester index of the result.
REQ-016 rsp_data  out  8  captured dot-product result.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, RUN, DRAIN and RESP.
REQ-018 IDLE: when req is nonzero, the block SHALL grant the only requester asserting req; if both assert, it SHALL grant the one not served last. It SHALL latch id and len[id], assert grant next cycle, and go to CLEAR.
REQ-019 CLEAR: mac_clr SHALL be 1 for exactly one cycle, the counter SHALL load len[id], and the FSM SHALL go to RUN.
REQ-020 RUN: op_ready[id] SHALL be 1; a pair SHALL be accepted when op_valid[id] and op_ready[id] are both 1 in cycle k.
REQ-021 For a pair accepted in cycle k, mac_a and mac_b SHALL hold that pair and mac_en SHALL be 1 in cycle k+1 only.
REQ-022 If no pair is accepted in a cycle, mac_en SHALL be 0 in the next cycle (bubble; no accumulation).
REQ-023 The counter SHALL decrement on each accept; the accept at count 0 SHALL be the last one, op_ready SHALL drop the next cycle, and the FSM SHALL go to DRAIN.
REQ-024 DRAIN SHALL last exactly 2 cycles, then rsp_data SHALL capture mac_out, rsp_id SHALL capture id, and the FSM SHALL go to RESP.
REQ-025 RESP: rsp_valid SHALL stay 1 with rsp_data and rsp_id stable until rsp_ready is 1; on that handshake the block SHALL record id as last-served, clear grant and go to IDLE.
REQ-026 The requester that is not granted SHALL see op_ready 0; its op_valid and req SHALL be ignored until IDLE.
REQ-027 Dropping req[id] mid-transaction SHALL NOT abort the transaction.
REQ-028 Arithmetic: the result SHALL be the sum of a*b over len+1 pairs, modulo 256 (maximum 72 for LEN_W=3, so no wrap occurs).
REQ-029 The earliest re-grant SHALL be the cycle after the RESP handshake; back-to-back requesters SHALL alternate.

Reset
REQ-030 While reset is 1, the FSM SHALL be in IDLE and grant, op_ready, mac_a, mac_b, mac_en, mac_clr, rsp_valid, rsp_id and rsp_data SHALL all be 0, with last-served = 1 so that requester 0 wins the first tie.
REQ-031 A reset during any state SHALL abandon the transaction without emitting a response; the next transaction SHALL start with CLEAR, so stale MAC contents are discarded.

Structure
REQ-032 A shared package mac_seq_pkg SHALL hold the state enum, N_REQ=2 and the default LEN_W.
REQ-033 Round-robin selection SHALL be a sub-module, rr_arbiter2, with inputs req and last and output one-hot gnt.

Verification
REQ-034 Single requester 0, len=2, pairs (3,3),(2,1),(1,2) with no bubbles -> one mac_clr pulse, three consecutive mac_en pulses, rsp_data=13, rsp_id=0.
REQ-035 Both req asserted from reset -> grant=01 first; after its response, grant=10; with both still asserting, the grants alternate 01,10,01.
REQ-036 Requester 1, len=1, op_valid with 2-cycle gaps, pairs (3,2),(3,3) -> mac_en only in the cycle after each accept, no extra accumulation, rsp_data=15.
REQ-037 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data and rsp_id stable for those cycles and no new grant until the handshake.
REQ-038 reset pulsed in RUN after 2 of 4 pairs -> all outputs 0 immediately, no response; the following transaction len=0, pair (2,2) -> rsp_data=4.
REQ-039 len=7 with all pairs (3,3) -> rsp_data=72, exactly 8 mac_en pulses.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// +------------------------------------------------------------------+
// | mac_seq_pkg : shared types and constants for the MAC sequencer   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

package mac_seq_pkg;

  localparam int N_REQ         = 2;
  localparam int DEFAULT_LEN_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// +------------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin arbiter, one-hot grant         |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mac_sequencer.sv
// +------------------------------------------------------------------+
// | mac_sequencer : arbitrates two requesters and streams operand    |
// |                 pairs into an external MAC, returns dot product  |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
`default_nettype none

module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [N_REQ-1:0]       op_valid,
  input  logic [2*N_REQ-1:0]     op_a,
  input  logic [2*N_REQ-1:0]     op_b,
  output logic [N_REQ-1:0]       op_ready,
  output logic [N_REQ-1:0]       grant,
  output logic [1:0]             mac_a,
  output logic [1:0]             mac_b,
  output logic                   mac_en,
  output logic                   mac_clr,
  input  logic [7:0]             mac_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [7:0]             rsp_data
);

  state_t           r_state;
  logic             r_id;
  logic             r_last;
  logic             r_drain;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;

  logic [1:0]       w_gnt;
  logic [LEN_W-1:0] w_len_sel;
  logic [1:0]       w_a;
  logic [1:0]       w_b;
  logic             w_accept;

  rr_arbiter2 u_arb (
    .req  (req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign w_len_sel = w_gnt[1] ? len[2*LEN_W-1:LEN_W] : len[LEN_W-1:0];
  assign w_a       = r_id ? op_a[3:2] : op_a[1:0];
  assign w_b       = r_id ? op_b[3:2] : op_b[1:0];
  assign w_accept  = op_valid[r_id] & op_ready[r_id];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      r_drain   <= 1'b0;
      r_len     <= '0;
      r_cnt     <= '0;
      grant     <= '0;
      op_ready  <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_id    <= w_gnt[1];
            r_len   <= w_len_sel;
            grant   <= w_gnt;
            mac_clr <= 1'b1;
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_cnt    <= r_len;
          op_ready <= grant;
          r_state  <= RUN;
        end
        RUN: begin
          if (w_accept) begin
            mac_a  <= w_a;
            mac_b  <= w_b;
            mac_en <= 1'b1;
            if (r_cnt == '0) begin
              op_ready <= '0;
              r_drain  <= 1'b0;
              r_state  <= DRAIN;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        // Two cycles let the final mac_en land in the accumulator before capture.
        DRAIN: begin
          if (r_drain) begin
            rsp_data  <= mac_out;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_drain <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_last    <= r_id;
            grant     <= '0;
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          grant     <= '0;
          op_ready  <= '0;
          rsp_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_sequencer.sv
// +------------------------------------------------------------------+
// | tb_mac_sequencer : randomized self-checking bench for the MAC    |
// |                    sequencer with a behavioural MAC + model      |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mac_sequencer;

  localparam int LEN_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req, op_valid, op_ready, grant;
  logic [2*LEN_W-1:0] len;
  logic [3:0]       op_a, op_b;
  logic [1:0]       mac_a, mac_b;
  logic             mac_en, mac_clr, rsp_valid, rsp_ready, rsp_id;
  logic [7:0]       mac_out, rsp_data;
  logic [7:0]       acc = 8'h5A;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pa [2][8];
  int   pb [2][8];
  int   last_served;
  bit   exp_en;
  int   exp_a, exp_b;
  int   n_en, n_clr;

  always #5 clk = ~clk;

  // Behavioural accumulator; deliberately not reset so stale contents must be cleared.
  always @(posedge clk) begin
    if (mac_clr)     acc <= 8'd0;
    else if (mac_en) acc <= acc + 8'(mac_a) * 8'(mac_b);
  end
  assign mac_out = acc;

  mac_sequencer #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .len       (len),
    .op_valid  (op_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_ready  (op_ready),
    .grant     (grant),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .mac_out   (mac_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mac_clr) n_clr++;
    if (mac_en)  n_en++;
    check("mac_en", 32'(mac_en), 32'(exp_en));
    if (exp_en) begin
      check("mac_a", 32'(mac_a), exp_a);
      check("mac_b", 32'(mac_b), exp_b);
    end
    exp_en = 1'b0;
    check("op_ready_ungranted", 32'(op_ready & ~grant), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; op_valid = '0; rsp_ready = 1'b0; exp_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    last_served = 1;
  endtask

  // One transaction: rv = request vector, gap_fixed forces valid only every third cycle.
  task automatic run_txn(input logic [1:0] rv, input int l0, input int l1, input int gap_pct,
                         input bit gap_fixed, input int hold, input bit drop, input int abort_at);
    int g, n, k, t, cyc;
    logic [7:0] exp_sum;
    req = rv;
    len = {LEN_W'(l1), LEN_W'(l0)};
    g = (rv == 2'b11) ? ((last_served == 1) ? 0 : 1) : (rv[1] ? 1 : 0);
    n = ((g == 0) ? l0 : l1) + 1;
    exp_sum = 8'd0;
    for (int i = 0; i < n; i++) exp_sum = exp_sum + 8'(pa[g][i] * pb[g][i]);
    n_en = 0; n_clr = 0;

    t = 0;
    while (grant == 2'b00 && t < 10) begin tick(); t++; end
    check("grant", 32'(grant), 32'(1 << g));

    k = 0; cyc = 0;
    while (k < n && cyc < 200) begin
      if (abort_at >= 0 && k == abort_at) begin
        #2 reset = 1'b1;
        #1 check("async_reset_outputs",
                 32'({grant, op_ready, mac_a, mac_b, mac_en, mac_clr, rsp_valid, rsp_id, rsp_data}), 0);
        req = '0; op_valid = '0;
        @(negedge clk);
        reset = 1'b0; exp_en = 1'b0; last_served = 1;
        for (int i = 0; i < 6; i++) begin
          tick();
          check("no_rsp_after_reset", 32'(rsp_valid), 0);
        end
        return;
      end
      op_valid = '0;
      op_valid[1-g] = 1'($urandom_range(0, 1));
      op_a = 4'($urandom); op_b = 4'($urandom);
      if (gap_fixed ? (cyc % 3 == 2) : ($urandom_range(0, 99) >= gap_pct)) begin
        op_valid[g] = 1'b1;
        op_a[2*g +: 2] = 2'(pa[g][k]);
        op_b[2*g +: 2] = 2'(pb[g][k]);
      end
      if (drop && k > 0) req[g] = 1'b0;
      if (op_valid[g] && op_ready[g]) begin
        exp_en = 1'b1; exp_a = pa[g][k]; exp_b = pb[g][k];
        k++;
      end
      tick(); cyc++;
    end
    op_valid = '0;
    check("pairs_accepted", k, n);
    check("op_ready_dropped", 32'(op_ready), 0);

    t = 1;
    while (!rsp_valid && t < 20) begin tick(); t++; end
    check("drain_latency", t, 3);
    check("rsp_data", 32'(rsp_data), 32'(exp_sum));
    check("rsp_id", 32'(rsp_id), g);
    check("mac_en_count", n_en, n);
    check("mac_clr_count", n_clr, 1);

    req = rv;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_data", 32'(rsp_data), 32'(exp_sum));
      check("hold_id", 32'(rsp_id), g);
      check("hold_grant", 32'(grant), 32'(1 << g));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_hs_valid", 32'(rsp_valid), 0);
    check("post_hs_grant", 32'(grant), 0);
    last_served = g;
    req = '0;
  endtask

  task automatic rand_pairs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) begin
        pa[r][i] = int'($urandom_range(0, 3));
        pb[r][i] = int'($urandom_range(0, 3));
      end
  endtask

  initial begin
    logic [1:0] rv;
    reset = 1'b1; req = '0; len = '0; op_valid = '0; op_a = '0; op_b = '0;
    rsp_ready = 1'b0; last_served = 1; exp_en = 1'b0; exp_a = 0; exp_b = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({grant, op_ready, mac_a, mac_b, mac_en, mac_clr, rsp_valid, rsp_id, rsp_data}), 0);
    reset = 1'b0;

    // Single requester 0, three pairs, no bubbles: 9+2+2 = 13.
    pa[0] = '{3, 2, 1, 0, 0, 0, 0, 0};
    pb[0] = '{3, 1, 2, 0, 0, 0, 0, 0};
    run_txn(2'b01, 2, 0, 0, 1'b0, 0, 1'b0, -1);

    // Tie from reset: alternation 01,10,01,10; long rsp_ready stall and req drop included.
    do_reset();
    rand_pairs();
    run_txn(2'b11, 3, 2, 20, 1'b0, 5, 1'b0, -1);
    run_txn(2'b11, 1, 4, 0, 1'b0, 0, 1'b1, -1);
    run_txn(2'b11, 2, 2, 30, 1'b0, 2, 1'b0, -1);
    run_txn(2'b11, 0, 5, 10, 1'b0, 1, 1'b0, -1);

    // Requester 1 with two-cycle gaps: 6+9 = 15.
    pa[1] = '{3, 3, 0, 0, 0, 0, 0, 0};
    pb[1] = '{2, 3, 0, 0, 0, 0, 0, 0};
    run_txn(2'b10, 0, 1, 0, 1'b1, 0, 1'b0, -1);

    // Reset mid-run after two of four pairs, then a fresh len=0 transaction: 2*2 = 4.
    rand_pairs();
    run_txn(2'b01, 3, 0, 0, 1'b0, 0, 1'b0, 2);
    pa[0][0] = 2; pb[0][0] = 2;
    run_txn(2'b01, 0, 0, 0, 1'b0, 0, 1'b0, -1);

    // Maximum length, all (3,3): 72.
    for (int i = 0; i < 8; i++) begin pa[1][i] = 3; pb[1][i] = 3; end
    run_txn(2'b10, 0, 7, 0, 1'b0, 0, 1'b0, -1);

    for (int it = 0; it < 14; it++) begin
      rand_pairs();
      rv = 2'($urandom_range(1, 3));
      run_txn(rv, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 60)), 1'b0, int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
